// File: rtl/dds_pkg.sv
// Shared constants and FSM encoding for the DDS sine generator and its period meter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dds_pkg;

    // Measurement FSM states of sine_period_meter.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meas_state_e;

    // Mid-scale of a 16-bit offset-binary sample and the default hysteresis half-width.
    localparam logic [15:0] DEF_MID  = 16'd32768;
    localparam logic [15:0] DEF_HYST = 16'd256;

    // Counter width shared with the DDS frequency constants.
    localparam int DEF_CNT_W = 24;

endpackage

// File: rtl/schmitt_cross_detect.sv
// Schmitt comparator on an unsigned sample: one-cycle rise pulse on each LOW->HIGH crossing.
// Latency: 1 cycle from s_i to rise_o/high_o.
// Backpressure: none; consumes one sample per clock.
// Ports: clk_i/rst_ni clock and async active-low reset; s_i registered sample;
//        mid_i/hyst_i threshold centre and half-width; rise_o crossing pulse; high_o comparator state.
module schmitt_cross_detect #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] s_i,
    input  logic [DATA_W-1:0] mid_i,
    input  logic [DATA_W-1:0] hyst_i,
    output logic              rise_o,
    output logic              high_o
);

    logic [DATA_W:0]   th_hi_sum;
    logic [DATA_W:0]   th_lo_diff;
    logic [DATA_W-1:0] th_hi;
    logic [DATA_W-1:0] th_lo;
    logic              high_q, high_d;
    logic              rise_q, rise_d;

    // One extra bit catches overflow/borrow so thresholds clamp to full scale / zero.
    assign th_hi_sum  = {1'b0, mid_i} + {1'b0, hyst_i};
    assign th_lo_diff = {1'b0, mid_i} - {1'b0, hyst_i};
    assign th_hi      = th_hi_sum[DATA_W]  ? '1 : th_hi_sum[DATA_W-1:0];
    assign th_lo      = th_lo_diff[DATA_W] ? '0 : th_lo_diff[DATA_W-1:0];

    always_comb begin
        high_d = high_q;
        rise_d = 1'b0;
        if (!high_q && (s_i >= th_hi)) begin
            high_d = 1'b1;
            rise_d = 1'b1;
        end else if (high_q && (s_i <= th_lo)) begin
            high_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            high_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            high_q <= high_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;
    assign high_o = high_q;

endmodule

// File: rtl/sine_period_meter.sv
// Measures the sine period (sys_clk cycles, averaged over 2^AVG_LOG2 periods) and peak-to-peak amplitude.
// Latency: meas_valid 3 cycles after the sample completing the final crossing of a window.
// Backpressure: none; one sample per clock, results are single-cycle strobes.
// Ports: sys_clk/sys_rst_n clock and async active-low reset; sine_in offset-binary samples;
//        meas_en run/idle level; period_out/vpp_out results; meas_valid result strobe; no_signal timeout flag.
module sine_period_meter
    import dds_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter logic [DATA_W-1:0] MID      = DATA_W'(DEF_MID),
    parameter logic [DATA_W-1:0] HYST     = DATA_W'(DEF_HYST),
    parameter int unsigned       CNT_W    = DEF_CNT_W,
    parameter int unsigned       AVG_LOG2 = 2,
    parameter int unsigned       TIMEOUT  = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] sine_in,
    input  logic              meas_en,
    output logic [CNT_W-1:0]  period_out,
    output logic [DATA_W-1:0] vpp_out,
    output logic              meas_valid,
    output logic              no_signal
);

    localparam int unsigned SUM_W  = CNT_W + AVG_LOG2;
    localparam int unsigned NPER_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [NPER_W-1:0] NPER_C    = NPER_W'(2 ** AVG_LOG2);

    meas_state_e       state_q, state_d;
    logic [DATA_W-1:0] s_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [NPER_W-1:0] nper_q, nper_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DATA_W-1:0] vpp_q, vpp_d;
    logic              nosig_q, nosig_d;

    logic              rise_pulse;
    logic              schmitt_high;
    logic              rise;
    logic [CNT_W-1:0]  cnt_inc;
    logic [SUM_W-1:0]  sum_add;
    logic [SUM_W-1:0]  avg;
    logic [NPER_W-1:0] nper_inc;
    logic [DATA_W-1:0] min_cur;
    logic [DATA_W-1:0] max_cur;

    schmitt_cross_detect #(
        .DATA_W (DATA_W)
    ) u_schmitt (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .s_i    (s_q),
        .mid_i  (MID),
        .hyst_i (HYST),
        .rise_o (rise_pulse),
        .high_o (schmitt_high)
    );

    // A rise pulse always coincides with the HIGH state; qualifying keeps both outputs meaningful.
    assign rise = rise_pulse & schmitt_high;

    // cnt sticks at TIMEOUT rather than wrapping, so a long gap can never alias to a short period.
    assign cnt_inc  = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);
    assign sum_add  = sum_q + SUM_W'(cnt_q);
    assign avg      = sum_add >> AVG_LOG2;
    assign nper_inc = nper_q + NPER_W'(1);
    assign min_cur  = (s_q < min_q) ? s_q : min_q;
    assign max_cur  = (s_q > max_q) ? s_q : max_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        nper_d   = nper_q;
        min_d    = min_q;
        max_d    = max_q;
        period_d = period_q;
        vpp_d    = vpp_q;
        nosig_d  = nosig_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (meas_en) begin
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                // The rise check comes first so a crossing on the timeout cycle still locks.
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    sum_d   = '0;
                    nper_d  = '0;
                    min_d   = s_q;
                    max_d   = s_q;
                    state_d = ST_MEASURE;
                end else if (cnt_q == TIMEOUT_C) begin
                    nosig_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_MEASURE: begin
                min_d = min_cur;
                max_d = max_cur;
                if (rise) begin
                    sum_d  = sum_add;
                    cnt_d  = CNT_W'(1);
                    nper_d = nper_inc;
                    // Results are loaded on entry to DONE so they are valid during the strobe.
                    if (nper_inc == NPER_C) begin
                        period_d = avg[CNT_W-1:0];
                        vpp_d    = max_cur - min_cur;
                        nosig_d  = 1'b0;
                        state_d  = ST_DONE;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    nosig_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                // cnt keeps running through DONE so the first period of the next window is intact.
                cnt_d   = cnt_inc;
                sum_d   = '0;
                nper_d  = '0;
                min_d   = s_q;
                max_d   = s_q;
                state_d = ST_MEASURE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disabling discards the window in flight, including one that would complete this cycle.
        if (!meas_en) begin
            state_d  = ST_IDLE;
            period_d = period_q;
            vpp_d    = vpp_q;
            nosig_d  = nosig_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            nper_q   <= '0;
            min_q    <= '0;
            max_q    <= '0;
            period_q <= '0;
            vpp_q    <= '0;
            nosig_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= sine_in;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            nper_q   <= nper_d;
            min_q    <= min_d;
            max_q    <= max_d;
            period_q <= period_d;
            vpp_q    <= vpp_d;
            nosig_q  <= nosig_d;
        end
    end

    assign period_out = period_q;
    assign vpp_out    = vpp_q;
    assign meas_valid = (state_q == ST_DONE);
    assign no_signal  = nosig_q;

endmodule

// File: tb/tb_sine_period_meter.sv
// Self-checking bench for sine_period_meter: directed scenarios with randomized square/sine stimulus.
// Expected results come from a sample-level crossing model over the whole stimulus record.
// Summary line reports comparison and error counts.
module tb_sine_period_meter;

    localparam int TIMEOUT = 1000;
    localparam int HI_TH   = 32768 + 256;
    localparam int LO_TH   = 32768 - 256;
    localparam logic [15:0] LO_LVL = 16'h1000;
    localparam logic [15:0] HI_LVL = 16'hF000;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] sine_in   = 16'h1000;
    logic        meas_en   = 1'b0;
    logic [23:0] period_out;
    logic [15:0] vpp_out;
    logic        meas_valid;
    logic        no_signal;

    typedef struct {
        int     t;
        longint per;
        int     vpp;
        bit     ns;
    } strobe_t;

    strobe_t     got[$];
    logic [15:0] wave[$];
    int          rises[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    sine_period_meter #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sine_in    (sine_in),
        .meas_en    (meas_en),
        .period_out (period_out),
        .vpp_out    (vpp_out),
        .meas_valid (meas_valid),
        .no_signal  (no_signal)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every result strobe with the cycle it was seen in.
    always @(negedge sys_clk) begin
        if (meas_valid === 1'b1) begin
            got.push_back('{t: cyc, per: longint'(period_out), vpp: int'(vpp_out), ns: no_signal});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Rising crossings of an ideal hysteresis comparator over the stimulus record.
    task automatic compute_rises();
        bit hi;
        hi = 1'b0;
        rises.delete();
        foreach (wave[i]) begin
            if (!hi && int'(wave[i]) >= HI_TH) begin
                hi = 1'b1;
                rises.push_back(i);
            end else if (hi && int'(wave[i]) <= LO_TH) begin
                hi = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] noise_sample();
        return ($urandom_range(0, 1) == 1) ? 16'd32868 : 16'd32668;
    endfunction

    task automatic add_square(input int lo_len, input int hi_len, input logic [15:0] lo,
                              input logic [15:0] hi, input int noise);
        repeat (lo_len) wave.push_back(lo);
        repeat (noise) wave.push_back(noise_sample());
        repeat (hi_len) wave.push_back(hi);
        repeat (noise) wave.push_back(noise_sample());
    endtask

    task automatic add_sine(input int period, input int nper);
        for (int n = 0; n < period * nper; n++) begin
            wave.push_back(16'($rtoi(32768.0 + 32767.0 * $sin(6.283185307179586 * n / period))));
        end
    endtask

    // Enable, play the record, disable, then compare every strobe against the model:
    // one result per 2^AVG_LOG2 crossings after the first, 3 cycles after the closing crossing.
    task automatic run_wave(input string tag, input int exp_vpp, input bit vpp_above);
        int n0;
        int nexp;
        int len;
        compute_rises();
        len  = wave.size();
        nexp = 0;
        for (int k = 4; k < rises.size(); k += 4) begin
            if (rises[k] + 3 <= len) nexp++;
        end
        got.delete();
        @(negedge sys_clk);
        n0      = cyc;
        meas_en = 1'b1;
        foreach (wave[i]) begin
            sine_in = wave[i];
            @(negedge sys_clk);
        end
        meas_en = 1'b0;
        sine_in = LO_LVL;
        repeat (5) @(negedge sys_clk);
        chk({tag, "_count"}, got.size(), nexp);
        for (int j = 0; j < nexp && j < got.size(); j++) begin
            int k;
            k = 4 * (j + 1);
            chk({tag, "_period"}, got[j].per, longint'((rises[k] - rises[k-4]) >> 2));
            chk({tag, "_time"}, got[j].t, n0 + rises[k] + 3);
            chk({tag, "_nosig"}, got[j].ns, 0);
            if (vpp_above) chk({tag, "_vpp_gt_f000"}, (got[j].vpp > 32'hF000), 1);
            else           chk({tag, "_vpp"}, got[j].vpp, exp_vpp);
        end
        wave.delete();
    endtask

    initial begin
        logic [15:0] lo_lvl;
        logic [15:0] hi_lvl;
        int          nz;
        int          n0;

        // Reset state.
        repeat (3) @(negedge sys_clk);
        chk("rst_period", period_out, 0);
        chk("rst_vpp", vpp_out, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_nosig", no_signal, 0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Square wave, 20 low / 30 high.
        repeat (13) add_square(20, 30, LO_LVL, HI_LVL, 0);
        run_wave("square50", 32'hE000, 1'b0);

        // Sampled sines at 50 and 25 cycles per period.
        add_sine(50, 14);
        run_wave("sine50", 0, 1'b1);
        add_sine(25, 28);
        run_wave("sine25", 0, 1'b1);

        // Noise inside the hysteresis band around each crossing, true period 40.
        repeat (14) add_square(16, 16, LO_LVL, HI_LVL, 4);
        run_wave("noisy40", 32'hE000, 1'b0);

        // Random levels, random per-period durations, optional noise.
        for (int rnd = 0; rnd < 3; rnd++) begin
            lo_lvl = 16'($urandom_range(0, LO_TH));
            hi_lvl = 16'($urandom_range(HI_TH, 65535));
            nz     = (rnd == 0) ? 0 : int'($urandom_range(0, 3));
            repeat (14) add_square(int'($urandom_range(2, 60)), int'($urandom_range(2, 60)),
                                   lo_lvl, hi_lvl, nz);
            run_wave("random", int'(hi_lvl) - int'(lo_lvl), 1'b0);
        end

        // Enable dropped after two periods: no strobe; next enable starts a fresh window.
        repeat (2) add_square(20, 30, LO_LVL, HI_LVL, 0);
        repeat (20) wave.push_back(LO_LVL);
        run_wave("partial", 32'hE000, 1'b0);
        repeat (13) add_square(20, 30, LO_LVL, HI_LVL, 0);
        run_wave("reenable", 32'hE000, 1'b0);

        // Flat mid-scale input: no_signal rises TIMEOUT+1 cycles after SYNC entry.
        @(negedge sys_clk);
        n0      = cyc;
        meas_en = 1'b1;
        sine_in = 16'h8000;
        repeat (TIMEOUT + 1) @(negedge sys_clk);
        chk("timeout_before", no_signal, 0);
        chk("timeout_cycle", cyc, n0 + TIMEOUT + 1);
        @(negedge sys_clk);
        chk("timeout_flag", no_signal, 1);
        repeat (13) add_square(20, 30, LO_LVL, HI_LVL, 0);
        run_wave("recover", 32'hE000, 1'b0);

        // Reset in the middle of a window.
        got.delete();
        repeat (3) add_square(20, 30, LO_LVL, HI_LVL, 0);
        @(negedge sys_clk);
        meas_en = 1'b1;
        foreach (wave[i]) begin
            sine_in = wave[i];
            @(negedge sys_clk);
        end
        wave.delete();
        chk("midrst_nostrobe", got.size(), 0);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_period", period_out, 0);
        chk("midrst_vpp", vpp_out, 0);
        chk("midrst_valid", meas_valid, 0);
        chk("midrst_nosig", no_signal, 0);
        meas_en = 1'b0;
        sine_in = LO_LVL;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        repeat (13) add_square(20, 30, LO_LVL, HI_LVL, 0);
        run_wave("after_rst", 32'hE000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
